// File: rtl/tcb_lib_pkg.sv
// Shared TCB library definitions: byte-order type and a lane swap helper.
package tcb_lib_pkg;

    typedef enum logic {
        TCB_LITTLE = 1'b0,
        TCB_BIG    = 1'b1
    } tcb_endian_t;

    localparam int TCB_MAX_DBW = 128;
    localparam logic [TCB_MAX_DBW-1:0] TCB_ONE = TCB_MAX_DBW'(1);

    // Lane i of the result takes lane bew-1-i of the source; callers zero-extend
    // their data to TCB_MAX_DBW and truncate the result back to their own width.
    function automatic logic [TCB_MAX_DBW-1:0] tcb_byte_swap(
        input logic [TCB_MAX_DBW-1:0] data,
        input int                     bew,
        input int                     slw
    );
        logic [TCB_MAX_DBW-1:0] res;
        int src;
        res = '0;
        for (int k = 0; k < TCB_MAX_DBW; k++) begin
            if (k < bew * slw) begin
                src = (bew - 1 - k / slw) * slw + k % slw;
                res = res | (((data >> src) & TCB_ONE) << k);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tcb_if.sv
// TCB bus bundle; the manager drives the request and the subordinate the response.
interface tcb_if #(
    parameter int ABW = 32,
    parameter int DBW = 32,
    parameter int SLW = 8
);
    localparam int BEW = DBW / SLW;

    logic           vld;
    logic           rdy;
    logic           wen;
    logic [ABW-1:0] adr;
    logic [BEW-1:0] ben;
    logic [DBW-1:0] wdt;
    logic [DBW-1:0] rdt;
    logic           err;

    modport man (output vld, wen, adr, ben, wdt, input  rdy, rdt, err);
    modport sub (input  vld, wen, adr, ben, wdt, output rdy, rdt, err);

endinterface

// File: rtl/tcb_lib_dly_pipe.sv
// Fixed-depth shift register carrying a valid tag and a payload, one stage per cycle.
module tcb_lib_dly_pipe #(
    parameter int DLY = 1,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    output logic         any_vld
);

    generate
        if (DLY == 0) begin : g_none
            assign out_vld = in_vld;
            assign out_dat = in_dat;
            assign any_vld = 1'b0;
        end else begin : g_pipe
            logic [DLY-1:0] tag;
            logic [W-1:0]   dat [DLY];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    tag <= '0;
                    for (int i = 0; i < DLY; i++) dat[i] <= '0;
                end else begin
                    tag[0] <= in_vld;
                    dat[0] <= in_dat;
                    for (int i = 1; i < DLY; i++) begin
                        tag[i] <= tag[i-1];
                        dat[i] <= dat[i-1];
                    end
                end
            end

            assign out_vld = tag[DLY-1];
            assign out_dat = dat[DLY-1];
            assign any_vld = |tag;
        end
    endgenerate

endmodule

// File: rtl/tcb_lib_endianness_cnv.sv
// TCB endianness converter: swaps write data/enables per transfer and swaps read
// data back using the byte order recorded for the matching request.
module tcb_lib_endianness_cnv
    import tcb_lib_pkg::*;
#(
    parameter int ABW = 32,
    parameter int DBW = 32,
    parameter int SLW = 8,
    parameter int BEW = DBW / SLW,
    parameter int DLY = 1,
    parameter int MOD = 1,
    parameter bit END = 1'b0,
    parameter int REG = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic ndn,
    output logic bsy,
    tcb_if.sub   sub,
    tcb_if.man   man
);

    tcb_endian_t    sel;
    logic           sub_xfr;
    logic [DBW-1:0] req_wdt;
    logic [BEW-1:0] req_ben;
    logic           slice_busy;
    logic           pipe_vld;
    logic [0:0]     pipe_dat;
    logic           pipe_any;
    logic           rsp_big;

    assign sel     = (MOD != 0) ? tcb_endian_t'(ndn) : tcb_endian_t'(END);
    assign sub_xfr = sub.vld & sub.rdy;

    assign req_wdt = (sel == TCB_BIG)
                   ? DBW'(tcb_byte_swap(TCB_MAX_DBW'(sub.wdt), BEW, SLW))
                   : sub.wdt;
    assign req_ben = (sel == TCB_BIG)
                   ? BEW'(tcb_byte_swap(TCB_MAX_DBW'(sub.ben), BEW, 1))
                   : sub.ben;

    generate
        if (REG != 0) begin : g_slice
            logic           r_vld;
            logic           r_wen;
            logic [ABW-1:0] r_adr;
            logic [BEW-1:0] r_ben;
            logic [DBW-1:0] r_wdt;

            // A new load always wins; otherwise the entry drains when the man side takes it.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_vld <= 1'b0;
                    r_wen <= 1'b0;
                    r_adr <= '0;
                    r_ben <= '0;
                    r_wdt <= '0;
                end else if (sub_xfr) begin
                    r_vld <= 1'b1;
                    r_wen <= sub.wen;
                    r_adr <= sub.adr;
                    r_ben <= req_ben;
                    r_wdt <= req_wdt;
                end else if (man.rdy) begin
                    r_vld <= 1'b0;
                end
            end

            assign sub.rdy    = ~r_vld | man.rdy;
            assign man.vld    = r_vld;
            assign man.wen    = r_wen;
            assign man.adr    = r_adr;
            assign man.ben    = r_ben;
            assign man.wdt    = r_wdt;
            assign slice_busy = r_vld;
        end else begin : g_bypass
            assign sub.rdy    = man.rdy;
            assign man.vld    = sub.vld & rst;
            assign man.wen    = sub.wen;
            assign man.adr    = sub.adr;
            assign man.ben    = req_ben;
            assign man.wdt    = req_wdt;
            assign slice_busy = 1'b0;
        end
    endgenerate

    tcb_lib_dly_pipe #(
        .DLY (DLY),
        .W   (1)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (sub_xfr),
        .in_dat  (1'(sel)),
        .out_vld (pipe_vld),
        .out_dat (pipe_dat),
        .any_vld (pipe_any)
    );

    // Without a delay the response shares the request cycle, so the live byte order applies.
    assign rsp_big = (DLY == 0) ? (sel == TCB_BIG) : (pipe_vld & pipe_dat[0]);

    assign sub.rdt = rsp_big
                   ? DBW'(tcb_byte_swap(TCB_MAX_DBW'(man.rdt), BEW, SLW))
                   : man.rdt;
    assign sub.err = man.err;
    assign bsy     = pipe_any | slice_busy;

endmodule

// File: tb/tb_tcb_lib_endianness_cnv.sv
// Bench for the endianness converter in three configurations: plain, sliced, fixed 64-bit big-endian.
module tb_tcb_lib_endianness_cnv;

    logic clk = 1'b0;
    logic rst;
    logic ndn0, ndn1, ndn2;
    logic bsy0, bsy1, bsy2;

    always #5 clk = ~clk;

    tcb_if #(.ABW(32), .DBW(32), .SLW(8)) s0 ();
    tcb_if #(.ABW(32), .DBW(32), .SLW(8)) m0 ();
    tcb_if #(.ABW(32), .DBW(32), .SLW(8)) s1 ();
    tcb_if #(.ABW(32), .DBW(32), .SLW(8)) m1 ();
    tcb_if #(.ABW(32), .DBW(64), .SLW(8)) s2 ();
    tcb_if #(.ABW(32), .DBW(64), .SLW(8)) m2 ();

    tcb_lib_endianness_cnv #(.DLY(1), .MOD(1), .REG(0)) u0 (
        .clk (clk), .rst (rst), .ndn (ndn0), .bsy (bsy0), .sub (s0), .man (m0)
    );
    tcb_lib_endianness_cnv #(.DLY(2), .MOD(1), .REG(1)) u1 (
        .clk (clk), .rst (rst), .ndn (ndn1), .bsy (bsy1), .sub (s1), .man (m1)
    );
    tcb_lib_endianness_cnv #(.DBW(64), .DLY(1), .MOD(0), .END(1'b1), .REG(0)) u2 (
        .clk (clk), .rst (rst), .ndn (ndn2), .bsy (bsy2), .sub (s2), .man (m2)
    );

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic        wen;
        logic [31:0] adr;
        logic [31:0] wdt;
        logic [3:0]  ben;
        logic        ndn;
        logic [31:0] rdt;
        logic        err;
        logic [31:0] exp_wdt;
        logic [3:0]  exp_ben;
        logic [31:0] exp_rdt;
    } vec_t;

    vec_t vecs [4];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference byte reversal done with plain shifts over whole bytes.
    function automatic logic [63:0] ref_swap(input logic [63:0] x, input int nbytes);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < nbytes; i++)
            r = r | (((x >> (8 * i)) & 64'hFF) << (8 * (nbytes - 1 - i)));
        return r;
    endfunction

    function automatic logic [63:0] ref_rev(input logic [63:0] x, input int nbits);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < nbits; i++)
            r = r | (((x >> i) & 64'h1) << (nbits - 1 - i));
        return r;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        s0.vld = 1'b1;
        s0.wen = v.wen;
        s0.adr = v.adr;
        s0.wdt = v.wdt;
        s0.ben = v.ben;
        ndn0   = v.ndn;
    endtask

    task automatic idle_all();
        s0.vld = 1'b0; s0.wen = 1'b0; s0.adr = '0; s0.wdt = '0; s0.ben = '0;
        s1.vld = 1'b0; s1.wen = 1'b0; s1.adr = '0; s1.wdt = '0; s1.ben = '0;
        s2.vld = 1'b0; s2.wen = 1'b0; s2.adr = '0; s2.wdt = '0; s2.ben = '0;
        m0.rdy = 1'b1; m0.rdt = '0; m0.err = 1'b0;
        m1.rdy = 1'b1; m1.rdt = '0; m1.err = 1'b0;
        m2.rdy = 1'b1; m2.rdt = '0; m2.err = 1'b0;
        ndn0 = 1'b0; ndn1 = 1'b0; ndn2 = 1'b0;
    endtask

    initial begin
        logic [31:0] slice_wdt_q [$];
        logic [3:0]  slice_ben_q [$];
        logic [31:0] slice_adr_q [$];
        bit          tag_q [$];
        bit          hist_xfr, hist_big;
        logic        exp_rdy, man_x, sub_x;
        logic [63:0] w64;
        int          sent, man_seen;

        vecs[0] = '{1'b1, 32'h0000_0010, 32'h0123_4567, 4'b0011, 1'b1, 32'h0000_00FF, 1'b0,
                    32'h6745_2301, 4'b1100, 32'hFF00_0000};
        vecs[1] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'b1111, 1'b1, 32'hFEDC_BA98, 1'b0,
                    32'h0000_0000, 4'b1111, 32'h98BA_DCFE};
        vecs[2] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'b1111, 1'b0, 32'hFEDC_BA98, 1'b0,
                    32'h0000_0000, 4'b1111, 32'hFEDC_BA98};
        vecs[3] = '{1'b1, 32'hDEAD_BEEC, 32'hA1B2_C3D4, 4'b1000, 1'b0, 32'h1234_5678, 1'b1,
                    32'hA1B2_C3D4, 4'b1000, 32'h1234_5678};

        // Reset state, with requests pending on the inputs.
        idle_all();
        rst = 1'b0;
        s0.vld = 1'b1;
        s1.vld = 1'b1;
        m1.rdy = 1'b0;
        #1;
        check_output("reset u0 man.vld", m0.vld, 0);
        check_output("reset u0 bsy", bsy0, 0);
        check_output("reset u1 man.vld", m1.vld, 0);
        check_output("reset u1 sub.rdy", s1.rdy, 1);
        check_output("reset u1 bsy", bsy1, 0);
        check_output("reset u0 sub.rdy follows", s0.rdy, m0.rdy);
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_all();
        rst = 1'b1;
        @(posedge clk);

        // Directed vectors: request in one cycle, response one cycle later.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            apply_stimulus(vecs[i]);
            #1;
            check_output($sformatf("vec%0d man.wdt", i), m0.wdt, vecs[i].exp_wdt);
            check_output($sformatf("vec%0d man.ben", i), m0.ben, vecs[i].exp_ben);
            check_output($sformatf("vec%0d man.adr", i), m0.adr, vecs[i].adr);
            check_output($sformatf("vec%0d man.wen", i), m0.wen, vecs[i].wen);
            @(posedge clk); #1;
            s0.vld = 1'b0;
            m0.rdt = vecs[i].rdt;
            m0.err = vecs[i].err;
            #1;
            check_output($sformatf("vec%0d sub.rdt", i), s0.rdt, vecs[i].exp_rdt);
            check_output($sformatf("vec%0d sub.err", i), s0.err, vecs[i].err);
            m0.err = 1'b0;
        end

        // Back-to-back reads with alternating byte order.
        @(posedge clk); #1;
        s0.vld = 1'b1; s0.wen = 1'b0; ndn0 = 1'b1;
        @(posedge clk); #1;
        ndn0 = 1'b0; m0.rdt = 32'h1122_3344;
        #1 check_output("b2b rsp0", s0.rdt, 32'h4433_2211);
        @(posedge clk); #1;
        ndn0 = 1'b1; m0.rdt = 32'h5566_7788;
        #1 check_output("b2b rsp1", s0.rdt, 32'h5566_7788);
        @(posedge clk); #1;
        s0.vld = 1'b0; m0.rdt = 32'h99AA_BBCC;
        #1 check_output("b2b rsp2", s0.rdt, 32'hCCBB_AA99);

        // Randomized traffic on the plain converter against a one-cycle-history model.
        @(posedge clk); #1;
        idle_all();
        @(posedge clk);
        hist_xfr = 1'b0;
        hist_big = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            s0.vld = 1'($urandom);
            s0.wen = 1'($urandom);
            s0.adr = $urandom;
            s0.wdt = $urandom;
            s0.ben = 4'($urandom);
            ndn0   = 1'($urandom);
            m0.rdy = 1'($urandom);
            m0.rdt = $urandom;
            m0.err = 1'($urandom);
            #1;
            check_output("rnd man.vld", m0.vld, s0.vld);
            check_output("rnd man.wdt", m0.wdt, ndn0 ? ref_swap(s0.wdt, 4) : 64'(s0.wdt));
            check_output("rnd man.ben", m0.ben, ndn0 ? ref_rev(s0.ben, 4) : 64'(s0.ben));
            check_output("rnd man.adr", m0.adr, s0.adr);
            check_output("rnd sub.rdy", s0.rdy, m0.rdy);
            check_output("rnd sub.rdt", s0.rdt,
                         (hist_xfr && hist_big) ? ref_swap(m0.rdt, 4) : 64'(m0.rdt));
            check_output("rnd sub.err", s0.err, m0.err);
            check_output("rnd bsy", bsy0, hist_xfr);
            hist_xfr = s0.vld && m0.rdy;
            hist_big = ndn0;
            @(posedge clk);
        end
        #1 idle_all();

        // Fixed big-endian 64-bit instance ignores ndn.
        @(posedge clk); #1;
        s2.vld = 1'b1; s2.wen = 1'b1; s2.wdt = 64'h0123_4567_89AB_CDEF; s2.ben = 8'h0F; ndn2 = 1'b0;
        #1;
        check_output("u2 man.wdt", m2.wdt, 64'hEFCD_AB89_6745_2301);
        check_output("u2 man.ben", m2.ben, 8'hF0);
        @(posedge clk); #1;
        s2.vld = 1'b0; m2.rdt = 64'h1122_3344_5566_7788;
        #1 check_output("u2 sub.rdt", s2.rdt, 64'h8877_6655_4433_2211);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            w64 = {$urandom, $urandom};
            s2.vld = 1'b1; s2.wdt = w64; ndn2 = 1'($urandom);
            #1 check_output("u2 rnd man.wdt", m2.wdt, ref_swap(w64, 8));
        end
        @(posedge clk); #1;
        idle_all();

        // Sliced instance: write burst with man.rdy held low for three cycles.
        sent = 0;
        man_seen = 0;
        tag_q = {1'b0, 1'b0};
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            s1.vld = (sent < 6);
            s1.wen = 1'b1;
            s1.adr = 32'h100 + 32'(sent) * 4;
            s1.wdt = 32'h0A0B_0C00 + 32'(sent);
            s1.ben = 4'b0001 << (sent % 4);
            ndn1   = sent[0];
            m1.rdy = !(c >= 2 && c <= 4);
            #1;
            exp_rdy = (slice_wdt_q.size() == 0) || m1.rdy;
            check_output("slice sub.rdy", s1.rdy, exp_rdy);
            check_output("slice man.vld", m1.vld, slice_wdt_q.size() != 0);
            if (slice_wdt_q.size() != 0) begin
                check_output("slice man.wdt", m1.wdt, slice_wdt_q[0]);
                check_output("slice man.ben", m1.ben, slice_ben_q[0]);
                check_output("slice man.adr", m1.adr, slice_adr_q[0]);
            end
            check_output("slice bsy", bsy1, (slice_wdt_q.size() != 0) || tag_q[0] || tag_q[1]);
            man_x = (slice_wdt_q.size() != 0) && m1.rdy;
            sub_x = s1.vld && exp_rdy;
            if (man_x) begin
                void'(slice_wdt_q.pop_front());
                void'(slice_ben_q.pop_front());
                void'(slice_adr_q.pop_front());
                man_seen++;
            end
            if (sub_x) begin
                slice_wdt_q.push_back(ndn1 ? 32'(ref_swap(s1.wdt, 4)) : s1.wdt);
                slice_ben_q.push_back(ndn1 ? 4'(ref_rev(s1.ben, 4)) : s1.ben);
                slice_adr_q.push_back(s1.adr);
                sent++;
            end
            void'(tag_q.pop_front());
            tag_q.push_back(sub_x);
        end
        check_output("slice man transfers", man_seen, 6);
        check_output("slice bsy final", bsy1, 0);

        // Reset between a read transfer and its response.
        @(posedge clk); #1;
        idle_all();
        s0.vld = 1'b1; ndn0 = 1'b1;
        s1.vld = 1'b1; ndn1 = 1'b1; m1.rdy = 1'b0;
        @(posedge clk); #1;
        s0.vld = 1'b0; s1.vld = 1'b0;
        #1;
        check_output("pre-reset u0 bsy", bsy0, 1);
        check_output("pre-reset u1 bsy", bsy1, 1);
        rst = 1'b0;
        #1;
        check_output("async u0 bsy", bsy0, 0);
        check_output("async u1 bsy", bsy1, 0);
        check_output("async u1 man.vld", m1.vld, 0);
        check_output("async u1 sub.rdy", s1.rdy, 1);
        m0.rdy = 1'b0;
        m0.rdt = 32'hA5A5_A5A5;
        #1;
        check_output("async u0 sub.rdy", s0.rdy, 0);
        check_output("async u0 sub.rdt", s0.rdt, 32'hA5A5_A5A5);
        @(negedge clk);
        rst = 1'b1;
        m0.rdy = 1'b1;
        m1.rdy = 1'b1;
        @(posedge clk); #1;
        check_output("post-reset sub.rdt", s0.rdt, 32'hA5A5_A5A5);
        check_output("post-reset bsy", bsy0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
